// File: rtl/fetch.sv
// fetch: instruction-fetch stage with PC, imem req/rdy/rvalid port and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            F_stall,
  input  logic            X_redirect,
  input  logic [XLEN-1:0] X_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] D_inst,
  output logic [XLEN-1:0] D_pc,
  output logic            D_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_if_q, pc_if_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] d_inst_q, d_inst_d;
  logic [XLEN-1:0] d_pc_q, d_pc_d;
  logic            d_valid_q, d_valid_d;
  logic            req;
  logic            accept;
  logic            ld;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_nxt;

  assign tgt       = X_target & ~XLEN'(3);
  assign pc_nxt    = pc_q + STEP;
  assign imem_req  = req && rst_n;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_rdy;
  assign D_inst    = d_inst_q;
  assign D_pc      = d_pc_q;
  assign D_valid   = d_valid_q;

  // Request valid: always in REQ, back-to-back only on a clean WAIT response.
  always_comb begin
    req = 1'b0;
    case (state_q)
      S_REQ:   req = 1'b1;
      S_WAIT:  req = imem_rvalid && !kill_q && !F_stall && !X_redirect;
      default: req = 1'b0;
    endcase
  end

  // Next-state, PC and IF/ID update; redirect outranks stall and responses.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_if_d     = pc_if_q;
    kill_d      = kill_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    d_inst_d    = d_inst_q;
    d_pc_d      = d_pc_q;
    d_valid_d   = d_valid_q;
    ld          = 1'b0;
    if (!F_stall || X_redirect) begin
      d_inst_d  = '0;
      d_pc_d    = '0;
      d_valid_d = 1'b0;
    end
    case (state_q)
      S_REQ: begin
        if (X_redirect) begin
          pc_d = tgt;
          if (accept) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (accept) begin
          pc_if_d = pc_q;
          pc_d    = pc_nxt;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (X_redirect) begin
          pc_d = tgt;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (F_stall) begin
            hold_inst_d = imem_rdata;
            hold_pc_d   = pc_if_q;
            state_d     = S_HOLD;
          end else begin
            d_inst_d = imem_rdata;
            d_pc_d   = pc_if_q;
            ld       = 1'b1;
            if (accept) begin
              pc_if_d = pc_q;
              pc_d    = pc_nxt;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_HOLD: begin
        if (X_redirect) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (!F_stall) begin
          d_inst_d = hold_inst_q;
          d_pc_d   = hold_pc_q;
          ld       = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (ld) d_valid_d = 1'b1;
  end

  // Fetch state and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      pc_if_q     <= '0;
      kill_q      <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      d_inst_q    <= '0;
      d_pc_q      <= '0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_if_q     <= pc_if_d;
      kill_q      <= kill_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      d_inst_q    <= d_inst_d;
      d_pc_q      <= d_pc_d;
      d_valid_q   <= d_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_q, pf_d;
  logic [31:0] ps_q, ps_d;

  assign perf_fetched = pf_q;
  assign perf_stall   = ps_q;

  // Saturating counts of valid IF/ID loads and stalled cycles.
  always_comb begin
    pf_d = pf_q;
    ps_d = ps_q;
    if (ld && d_valid_d && pf_q != 32'hFFFF_FFFF) pf_d = pf_q + 32'd1;
    if (F_stall && ps_q != 32'hFFFF_FFFF) ps_d = ps_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_q <= '0;
      ps_q <= '0;
    end else begin
      pf_q <= pf_d;
      ps_q <= ps_d;
    end
  end
`endif

endmodule
